// File: rtl/jstk_pkg.sv
// Shared constants for the PmodJSTK SPI link: frame layout, LED command prefix,
// button bit positions and responder FSM state encoding.
package jstk_pkg;

  localparam int FRAME_BITS = 40;
  localparam logic [5:0] LED_CMD_PREFIX = 6'b100000;

  localparam int BTN_C = 0;
  localparam int BTN_J = 1;
  localparam int BTN_Z = 2;

  // Byte order on the wire; byte 0 goes out first (MSB of the frame word).
  localparam int BYTE_Y_LO = 0;
  localparam int BYTE_Y_HI = 1;
  localparam int BYTE_X_LO = 2;
  localparam int BYTE_X_HI = 3;
  localparam int BYTE_BTN  = 4;

  typedef logic [1:0] jstk_state_t;
  localparam jstk_state_t ST_WAIT_IDLE = 2'd0;
  localparam jstk_state_t ST_IDLE      = 2'd1;
  localparam jstk_state_t ST_ACTIVE    = 2'd2;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic       c,
    input logic       j,
    input logic       z
  );
    logic [FRAME_BITS-1:0] f;
    logic [7:0]            btn;
    f          = '0;
    btn        = '0;
    btn[BTN_C] = c;
    btn[BTN_J] = j;
    btn[BTN_Z] = z;
    f[FRAME_BITS-1-8*BYTE_Y_LO -: 8] = y[7:0];
    f[FRAME_BITS-1-8*BYTE_Y_HI -: 8] = {6'b0, y[9:8]};
    f[FRAME_BITS-1-8*BYTE_X_LO -: 8] = x[7:0];
    f[FRAME_BITS-1-8*BYTE_X_HI -: 8] = {6'b0, x[9:8]};
    f[FRAME_BITS-1-8*BYTE_BTN  -: 8] = btn;
    return f;
  endfunction

endpackage

// File: rtl/jstk_spi_responder_sync_ff.sv
// Single-bit multi-stage synchronizer for asynchronous SPI pins.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stg;

  // Clearing to 0 makes a just-reset responder treat SS as low until it is truly seen high.
  always_ff @(posedge clk) begin
    if (reset) stg <= '0;
    else       stg <= {stg[STAGES-2:0], d};
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/jstk_spi_responder.sv
// PmodJSTK emulator: SPI mode-0 slave returning joystick position/buttons and
// capturing the LED command byte sent by the host.
//
// state        | meaning
// WAIT_IDLE    | after reset; wait for SS high so a frame is never joined mid-stream
// IDLE         | SS high; on SS fall snapshot inputs and start a frame
// ACTIVE       | frame in flight; shift rx on SCLK rise, tx on SCLK fall, end on SS rise
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       btn_c,
  input  logic       btn_j,
  input  logic       btn_z,
  output logic [1:0] led,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [5:0] FRAME_CNT = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_MAX   = 6'd63;
  localparam logic [5:0] CMD_LAST  = 6'd7;

  logic ss_s, sclk_s, mosi_s;
  logic ss_q, sclk_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ss   (.clk(clk), .reset(reset), .d(SS),   .q(ss_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .reset(reset), .d(SCLK), .q(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .reset(reset), .d(MOSI), .q(mosi_s));

  logic ss_fall, ss_rise, sclk_rise, sclk_fall;
  assign ss_fall   =  ss_q   & ~ss_s;
  assign ss_rise   = ~ss_q   &  ss_s;
  assign sclk_rise = ~sclk_q &  sclk_s;
  assign sclk_fall =  sclk_q & ~sclk_s;

  jstk_state_t           state;
  logic [FRAME_BITS-1:0] tx_sh;
  logic [6:0]            rx_sh;
  logic [5:0]            bit_cnt;
  logic [1:0]            led_pend;
  logic                  cmd_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_WAIT_IDLE;
      ss_q       <= 1'b0;
      sclk_q     <= 1'b0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      bit_cnt    <= '0;
      led_pend   <= 2'b00;
      cmd_ok     <= 1'b0;
      led        <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ss_q       <= ss_s;
      sclk_q     <= sclk_s;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        ST_WAIT_IDLE: begin
          if (ss_s) state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (ss_fall) begin
            tx_sh   <= build_frame(x_pos, y_pos, btn_c, btn_j, btn_z);
            rx_sh   <= '0;
            bit_cnt <= '0;
            cmd_ok  <= 1'b0;
            state   <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (ss_rise) begin
            state <= ST_IDLE;
            if (bit_cnt == FRAME_CNT) begin
              frame_done <= 1'b1;
              if (cmd_ok) led <= led_pend;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_sh <= {rx_sh[5:0], mosi_s};
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 6'd1;
              // Eighth bit completes byte 0: rx_sh[6:1] is cmd[7:2], {rx_sh[0], mosi_s} is cmd[1:0].
              if (bit_cnt == CMD_LAST) begin
                cmd_ok   <= (rx_sh[6:1] == LED_CMD_PREFIX);
                led_pend <= {rx_sh[0], mosi_s};
              end
            end
            if (sclk_fall) tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
          end
        end

        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

  assign MISO = (state == ST_ACTIVE) & tx_sh[FRAME_BITS-1];

endmodule
